data_memory_interface: RTL and testbench
========================================

// Module: data_memory_interface
// PURPOSE
//  Sits directly downstream of the pipelined datapath's MEM stage. Turns its load/store request
//  (byte address, write data, funct3 format, read/write enables) into a word-addressed,
//  byte-strobed bus transaction with a ready handshake. Aligns and sign-extends load data.
//  Raises stall to freeze the pipeline until the access completes.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max BUSY cycles waiting for bus_ready before abort (1..65535)
// PORTS
//  clock              in   1   single clock, all state on rising edge
//  reset              in   1   synchronous, active-high
//  address            in   32  byte address from MEM stage (ALU result)
//  write_data         in   32  store data (rs2) from MEM stage
//  format             in   3   funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  read_enable        in   1   load request
//  write_enable       in   1   store request
//  read_data          out  32  formatted load result, registered
//  stall              out  1   hold pipeline (pc/IF/ID/EX/MEM) this cycle
//  misaligned         out  1   one-cycle pulse: misaligned access rejected
//  bus_error          out  1   sticky: a transaction timed out
//  bus_address        out  32  {address[31:2],2'b00}, latched
//  bus_write_data     out  32  lane-replicated store data, latched
//  bus_byte_enable    out  4   active byte lanes, latched
//  bus_read_request   out  1   read transaction pending
//  bus_write_request  out  1   write transaction pending
//  bus_ready          in   1   bus completes current transaction this cycle
//  bus_read_data      in   32  raw word, valid when bus_ready & bus_read_request
// BEHAVIOUR
//  Reset: state IDLE. read_data=0, misaligned=0, bus_error=0, both requests=0.
//   bus_address, bus_write_data, bus_byte_enable=0, timeout counter=0.
//  FSM IDLE -> BUSY -> DONE -> IDLE.
//  IDLE:
//   - Access = read_enable|write_enable. If both are set, the write wins and no read occurs.
//   - Aligned access: latch the bus_* fields and the load format/offset. Go to BUSY.
//     stall=1 combinationally in this same cycle.
//   - Misaligned access (H with address[0]=1; W with address[1:0]!=0): no bus activity.
//     stall=0. misaligned=1 in the following cycle. read_data<=0. Stay IDLE.
//   - Format 011/110/111 is treated as W.
//  BUSY:
//   - Selected request held high. All bus_* outputs held stable. stall=1.
//   - Counter increments each BUSY cycle.
//   - On bus_ready: drop request, load read_data with the formatted word (loads only), go to DONE.
//   - If counter reaches TIMEOUT_CYCLES without bus_ready: drop request, read_data<=0,
//     bus_error<=1, go to DONE.
//  DONE:
//   - stall=0 for exactly one cycle, so the pipeline advances past the access.
//   - The enables still asserted in DONE belong to the finished access and are ignored.
//   - Next state IDLE. Counter is cleared.
//  Minimum latency: 2 stall cycles (IDLE, BUSY with bus_ready=1). Data is valid in the DONE cycle.
//  read_data holds its value until the next completed load, misaligned access, or reset.
//  Stores leave read_data unchanged.
//  Store lanes (k=address[1:0]):
//   - B: byte_enable = 1<<k, data = {4{wd[7:0]}}.
//   - H: byte_enable = k[1] ? 1100 : 0011, data = {2{wd[15:0]}}.
//   - W: byte_enable = 1111, data = wd.
//  Load extract:
//   - Shift the word right by 8*k.
//   - B/H are sign-extended from bit 7/15. BU/HU are zero-extended. W is passed through.
//  Reset mid-transaction: at the next edge, requests drop, state returns to IDLE,
//   the bus response is discarded, and bus_error is cleared.
//  bus_ready outside BUSY is ignored.
// TESTING
//  1. LW at 0x100, bus_ready on the first BUSY cycle, data 0xDEADBEEF ->
//     stall high 2 cycles, bus_address 0x100, byte_enable 1111, read_data 0xDEADBEEF in DONE.
//  2. LB at 0x203, word 0x80FF1122 -> read_data 0xFFFFFF80.
//     Repeat as LBU -> 0x00000080. LHU at 0x202 -> 0x000080FF.
//  3. SB at 0x007, write_data 0x000000A5 -> bus_write_request, byte_enable 1000,
//     bus_write_data 0xA5A5A5A5, bus_address 0x004, read_data unchanged.
//  4. LW at 0x102 -> no bus request, stall never high, misaligned pulse 1 cycle,
//     read_data 0. Also SH at 0x001 -> same.
//  5. TIMEOUT_CYCLES=4, bus_ready held 0 -> request high 4 cycles then low,
//     bus_error=1 and sticky, read_data 0, stall releases in DONE.
//  6. Reset asserted mid-BUSY with bus_ready pulsing in the same cycle -> next cycle IDLE,
//     requests 0, read_data 0. Both enables set at 0x10 -> write only.

Source files
------------

// File: rtl/data_memory_interface.sv
// MEM-stage load/store to word-addressed, byte-strobed bus bridge with load alignment and sign extension.
// Latency: 2 stall cycles minimum, result valid in DONE; stall holds the pipeline until bus_ready or timeout.
module data_memory_interface #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic [2:0]  format,
    input  logic        read_enable,
    input  logic        write_enable,
    output logic [31:0] read_data,
    output logic        stall,
    output logic        misaligned,
    output logic        bus_error,
    output logic [31:0] bus_address,
    output logic [31:0] bus_write_data,
    output logic [3:0]  bus_byte_enable,
    output logic        bus_read_request,
    output logic        bus_write_request,
    input  logic        bus_ready,
    input  logic [31:0] bus_read_data
);

    localparam logic [1:0]  S_IDLE = 2'd0;
    localparam logic [1:0]  S_BUSY = 2'd1;
    localparam logic [1:0]  S_DONE = 2'd2;
    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

    logic [1:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        misaligned_q, misaligned_d;
    logic        bus_error_q, bus_error_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        rd_req_q, rd_req_d;
    logic        wr_req_q, wr_req_d;
    logic [2:0]  fmt_q, fmt_d;
    logic [1:0]  off_q, off_d;

    logic        access, is_b, is_h, misalign, timeout;
    logic [1:0]  k;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata, shifted, load_word;
    logic [15:0] cnt_inc;

    // Only funct3[1:0] distinguishes B/H; every other encoding behaves as a word access.
    always_comb begin
        access   = read_enable | write_enable;
        k        = address[1:0];
        is_b     = (format[1:0] == 2'b00);
        is_h     = (format[1:0] == 2'b01);
        misalign = is_h ? k[0] : (!is_b && (k != 2'b00));
        if (is_b) begin
            lane_be    = 4'b0001 << k;
            lane_wdata = {4{write_data[7:0]}};
        end else if (is_h) begin
            lane_be    = k[1] ? 4'b1100 : 4'b0011;
            lane_wdata = {2{write_data[15:0]}};
        end else begin
            lane_be    = 4'b1111;
            lane_wdata = write_data;
        end
    end

    always_comb begin
        shifted = bus_read_data >> {off_q, 3'b000};
        case (fmt_q[1:0])
            2'b00:   load_word = {{24{~fmt_q[2] & shifted[7]}}, shifted[7:0]};
            2'b01:   load_word = {{16{~fmt_q[2] & shifted[15]}}, shifted[15:0]};
            default: load_word = shifted;
        endcase
        cnt_inc = cnt_q + 16'd1;
        timeout = (cnt_inc >= TIMEOUT_LIMIT);
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rd_data_d    = rd_data_q;
        misaligned_d = 1'b0;
        bus_error_d  = bus_error_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        rd_req_d     = rd_req_q;
        wr_req_d     = wr_req_q;
        fmt_d        = fmt_q;
        off_d        = off_q;
        stall        = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = 16'd0;
                if (access && misalign) begin
                    misaligned_d = 1'b1;
                    rd_data_d    = 32'd0;
                end else if (access) begin
                    stall    = 1'b1;
                    addr_d   = {address[31:2], 2'b00};
                    wdata_d  = lane_wdata;
                    be_d     = lane_be;
                    wr_req_d = write_enable;
                    rd_req_d = ~write_enable;
                    fmt_d    = format;
                    off_d    = k;
                    state_d  = S_BUSY;
                end
            end
            S_BUSY: begin
                stall = 1'b1;
                cnt_d = cnt_inc;
                if (bus_ready) begin
                    rd_req_d = 1'b0;
                    wr_req_d = 1'b0;
                    if (rd_req_q) rd_data_d = load_word;
                    state_d = S_DONE;
                end else if (timeout) begin
                    rd_req_d    = 1'b0;
                    wr_req_d    = 1'b0;
                    rd_data_d   = 32'd0;
                    bus_error_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                // Enables seen here still belong to the access just finished.
                cnt_d   = 16'd0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 16'd0;
            rd_data_q    <= 32'd0;
            misaligned_q <= 1'b0;
            bus_error_q  <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            be_q         <= 4'd0;
            rd_req_q     <= 1'b0;
            wr_req_q     <= 1'b0;
            fmt_q        <= 3'd0;
            off_q        <= 2'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rd_data_q    <= rd_data_d;
            misaligned_q <= misaligned_d;
            bus_error_q  <= bus_error_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            rd_req_q     <= rd_req_d;
            wr_req_q     <= wr_req_d;
            fmt_q        <= fmt_d;
            off_q        <= off_d;
        end
    end

    assign read_data         = rd_data_q;
    assign misaligned        = misaligned_q;
    assign bus_error         = bus_error_q;
    assign bus_address       = addr_q;
    assign bus_write_data    = wdata_q;
    assign bus_byte_enable   = be_q;
    assign bus_read_request  = rd_req_q;
    assign bus_write_request = wr_req_q;

endmodule

// File: tb/tb_data_memory_interface.sv
// Bench for data_memory_interface: directed cases plus randomized accesses against a byte-lane model.
module tb_data_memory_interface;

    localparam int TO = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] address, write_data, read_data, bus_address, bus_write_data, bus_read_data;
    logic [2:0]  format;
    logic        read_enable, write_enable, stall, misaligned, bus_error;
    logic [3:0]  bus_byte_enable;
    logic        bus_read_request, bus_write_request, bus_ready;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_rd;

    always #5 clock = ~clock;

    data_memory_interface #(.TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset(reset), .address(address), .write_data(write_data),
        .format(format), .read_enable(read_enable), .write_enable(write_enable),
        .read_data(read_data), .stall(stall), .misaligned(misaligned), .bus_error(bus_error),
        .bus_address(bus_address), .bus_write_data(bus_write_data),
        .bus_byte_enable(bus_byte_enable), .bus_read_request(bus_read_request),
        .bus_write_request(bus_write_request), .bus_ready(bus_ready),
        .bus_read_data(bus_read_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    // 0 = byte, 1 = half, 2 = word
    function automatic int kind(input logic [2:0] f);
        if (f == 3'b000 || f == 3'b100) return 0;
        if (f == 3'b001 || f == 3'b101) return 1;
        return 2;
    endfunction

    function automatic bit is_mis(input logic [2:0] f, input logic [31:0] a);
        if (kind(f) == 1) return (a % 2) != 0;
        if (kind(f) == 2) return (a % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] f, input int k);
        if (kind(f) == 0) return 4'(1 << k);
        if (kind(f) == 1) return (k >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] exp_wd(input logic [2:0] f, input logic [31:0] wd);
        if (kind(f) == 0) return (wd % 256) * 32'h0101_0101;
        if (kind(f) == 1) return (wd % 65536) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f, input int k, input logic [31:0] word);
        logic [31:0] v;
        logic [31:0] b;
        logic [31:0] h;
        v = word >> (8 * k);
        b = v % 256;
        h = v % 65536;
        case (f)
            3'b000:  return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
            3'b100:  return b;
            3'b001:  return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
            3'b101:  return h;
            default: return v;
        endcase
    endfunction

    task automatic do_access(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f,
                             input logic re, input logic we, input int dly,
                             input logic [31:0] word, input string tag);
        int stalls;
        int k;
        stalls = 0;
        k = int'(a % 4);
        address = a; write_data = wd; format = f;
        read_enable = re; write_enable = we;
        #1;
        if (is_mis(f, a)) begin
            chk({tag, " stall_mis"}, 32'(stall), 32'd0);
            step;
            read_enable = 1'b0; write_enable = 1'b0;
            #1;
            exp_rd = 32'd0;
            chk({tag, " mis_pulse"}, 32'(misaligned), 32'd1);
            chk({tag, " mis_noreq"}, 32'({bus_read_request, bus_write_request}), 32'd0);
            chk({tag, " mis_rdata"}, read_data, exp_rd);
            step;
            chk({tag, " mis_clear"}, 32'(misaligned), 32'd0);
        end else begin
            if (stall) stalls++;
            step;
            for (int i = 0; i <= dly; i++) begin
                bus_ready     = (i == dly);
                bus_read_data = (i == dly) ? word : $urandom;
                #1;
                if (stall) stalls++;
                chk({tag, " req"}, 32'({bus_read_request, bus_write_request}), we ? 32'd1 : 32'd2);
                chk({tag, " addr"}, bus_address, a & 32'hFFFF_FFFC);
                if (i == 0) begin
                    chk({tag, " be"}, 32'(bus_byte_enable), 32'(exp_be(f, k)));
                    if (we) chk({tag, " wdata"}, bus_write_data, exp_wd(f, wd));
                end
                step;
            end
            bus_ready = 1'b0;
            #1;
            if (!we) exp_rd = exp_load(f, k, word);
            chk({tag, " done_stall"}, 32'(stall), 32'd0);
            chk({tag, " done_req"}, 32'({bus_read_request, bus_write_request}), 32'd0);
            chk({tag, " rdata"}, read_data, exp_rd);
            chk({tag, " stall_cycles"}, 32'(stalls), 32'(dly + 2));
            read_enable = 1'b0; write_enable = 1'b0;
            step;
        end
    endtask

    initial begin
        reset = 1'b1; address = 0; write_data = 0; format = 0;
        read_enable = 0; write_enable = 0; bus_ready = 0; bus_read_data = 0;
        exp_rd = 32'd0;
        step; step;
        chk("rst_rdata", read_data, 32'd0);
        chk("rst_flags", 32'({misaligned, bus_error, stall}), 32'd0);
        chk("rst_req", 32'({bus_read_request, bus_write_request}), 32'd0);
        chk("rst_addr", bus_address, 32'd0);
        chk("rst_wdata", bus_write_data, 32'd0);
        chk("rst_be", 32'(bus_byte_enable), 32'd0);
        reset = 1'b0;
        step;

        do_access(32'h100, 32'h0, 3'b010, 1, 0, 0, 32'hDEAD_BEEF, "lw");
        chk("lw_const", read_data, 32'hDEAD_BEEF);
        do_access(32'h203, 32'h0, 3'b000, 1, 0, 1, 32'h80FF_1122, "lb");
        chk("lb_const", read_data, 32'hFFFF_FF80);
        do_access(32'h203, 32'h0, 3'b100, 1, 0, 2, 32'h80FF_1122, "lbu");
        chk("lbu_const", read_data, 32'h0000_0080);
        do_access(32'h202, 32'h0, 3'b101, 1, 0, 0, 32'h80FF_1122, "lhu");
        chk("lhu_const", read_data, 32'h0000_80FF);
        do_access(32'h007, 32'hA5, 3'b000, 0, 1, 0, 32'h0, "sb");
        chk("sb_be", 32'(bus_byte_enable), 32'h8);
        chk("sb_wd", bus_write_data, 32'hA5A5_A5A5);
        chk("sb_addr", bus_address, 32'h4);
        chk("sb_keep", read_data, 32'h0000_80FF);
        do_access(32'h102, 32'h0, 3'b010, 1, 0, 0, 32'h0, "lw_mis");
        do_access(32'h001, 32'h1234, 3'b001, 0, 1, 0, 32'h0, "sh_mis");
        do_access(32'h010, 32'hCAFE_F00D, 3'b010, 1, 1, 1, 32'h1111_2222, "both");

        for (int n = 0; n < 40; n++) begin
            int r;
            r = $urandom_range(1, 3);
            do_access($urandom, $urandom, 3'($urandom_range(0, 7)), r[0], r[1],
                      $urandom_range(0, TO - 1), $urandom, "rnd");
        end

        bus_ready = 1'b1; bus_read_data = 32'h5555_AAAA;
        step;
        bus_ready = 1'b0;
        #1;
        chk("idle_ready_rdata", read_data, exp_rd);
        chk("idle_ready_req", 32'({bus_read_request, bus_write_request}), 32'd0);

        address = 32'h40; format = 3'b010; read_enable = 1'b1;
        #1;
        chk("to_stall0", 32'(stall), 32'd1);
        step;
        for (int i = 0; i < TO; i++) begin
            chk("to_req", 32'(bus_read_request), 32'd1);
            step;
        end
        exp_rd = 32'd0;
        chk("to_req_low", 32'(bus_read_request), 32'd0);
        chk("to_err", 32'(bus_error), 32'd1);
        chk("to_rdata", read_data, exp_rd);
        chk("to_stall", 32'(stall), 32'd0);
        read_enable = 1'b0;
        step;
        chk("to_sticky", 32'(bus_error), 32'd1);
        do_access(32'h44, 32'h0, 3'b001, 1, 0, 0, 32'h8001_7FFF, "after_to");
        chk("to_sticky2", 32'(bus_error), 32'd1);

        address = 32'h100; format = 3'b010; read_enable = 1'b1;
        step;
        reset = 1'b1; bus_ready = 1'b1; bus_read_data = 32'h1234_5678;
        step;
        reset = 1'b0; bus_ready = 1'b0; read_enable = 1'b0;
        #1;
        exp_rd = 32'd0;
        chk("mrst_req", 32'({bus_read_request, bus_write_request}), 32'd0);
        chk("mrst_rdata", read_data, exp_rd);
        chk("mrst_err", 32'(bus_error), 32'd0);
        chk("mrst_stall", 32'(stall), 32'd0);
        step;
        chk("mrst_idle", 32'({stall, bus_read_request, bus_write_request}), 32'd0);
        do_access(32'h10, 32'h0BAD_F00D, 3'b010, 1, 1, 0, 32'h0, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
